fetch_module: RTL and testbench

Instruction-fetch stage of the pipelined LC-3b datapath. It is the consumer of the branch-resolution signals (`branch_enable`, `br_adder_out`) produced at writeback. It owns the fetch PC and issues reads on the instruction-memory port using the read/resp handshake. It delivers instruction/PC pairs to decode through a valid/stall output register backed by a one-entry skid buffer, and flushes all wrong-path instructions on redirect.

---
 rtl/fetch_module.sv | 152 +++++++++++++++
 tb/tb_fetch_module.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_module.sv
// Instruction-fetch stage for the pipelined LC-3b: owns the fetch PC, talks to
// instruction memory with a read/resp handshake, and feeds decode through an
// output register plus a one-entry skid buffer.
module fetch_module #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_enable,
  input  logic [15:0] br_adder_out,
  input  logic        stall,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [1:0]  dbg_state
);

  // Handshakes:
  //   memory: a request is open while imem_read=1; imem_address is held until the
  //           cycle imem_resp=1, and an open request is never withdrawn or re-aimed.
  //   decode: the word in if_ir/if_pc is taken on any cycle with if_valid && !stall.
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_ir_q, out_ir_d;
  logic [15:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_ir_q, skid_ir_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] next_addr;

  // if_pc is the fetch address + 2, which is also the next sequential fetch.
  assign next_addr = req_addr_q + 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_START;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_ir_q     <= 16'h0000;
      out_pc_q     <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_ir_q    <= 16'h0000;
      skid_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      out_valid_q  <= out_valid_d;
      out_ir_q     <= out_ir_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    out_valid_d  = out_valid_q;
    out_ir_d     = out_ir_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;
    imem_read    = 1'b0;

    if (out_valid_q && !stall) out_valid_d = 1'b0;

    case (state_q)
      S_START: begin
        state_d    = S_FETCH;
        req_addr_d = pc_q;
        if (branch_enable) begin
          pc_d       = br_adder_out;
          req_addr_d = br_adder_out;
        end
      end
      S_FETCH: begin
        imem_read = 1'b1;
        if (branch_enable) begin
          pc_d = br_adder_out;
          if (imem_resp) req_addr_d = br_adder_out;
          else           state_d    = S_DRAIN;
        end else if (imem_resp) begin
          pc_d = next_addr;
          if (!out_valid_q || !stall) begin
            out_valid_d = 1'b1;
            out_ir_d    = imem_rdata;
            out_pc_d    = next_addr;
            req_addr_d  = next_addr;
          end else begin
            // Decode is blocked: park the word and stop requesting until it drains.
            skid_valid_d = 1'b1;
            skid_ir_d    = imem_rdata;
            skid_pc_d    = next_addr;
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (branch_enable) begin
          skid_valid_d = 1'b0;
          pc_d         = br_adder_out;
          req_addr_d   = br_adder_out;
          state_d      = S_FETCH;
        end else if (!stall) begin
          out_valid_d  = skid_valid_q;
          out_ir_d     = skid_ir_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
          req_addr_d   = pc_q;
          state_d      = S_FETCH;
        end
      end
      S_DRAIN: begin
        // The old request stays on the bus until memory answers; its data is dropped.
        imem_read = 1'b1;
        if (branch_enable) pc_d = br_adder_out;
        if (imem_resp) begin
          req_addr_d = branch_enable ? br_adder_out : pc_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_START;
    endcase

    if (branch_enable) out_valid_d = 1'b0;
  end

  assign imem_address = req_addr_q;
  assign if_valid     = out_valid_q;
  assign if_ir        = out_ir_q;
  assign if_pc        = out_pc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_module.sv
// Directed bench for fetch_module: behavioural memory, a delivered-stream model
// checked every cycle, and hand-computed expectations along the test sequence.
module tb_fetch_module;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        branch_enable;
  logic [15:0] br_adder_out;
  logic        stall;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_ir;
  logic [15:0] if_pc;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_module #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .branch_enable(branch_enable), .br_adder_out(br_adder_out), .stall(stall),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .dbg_state(dbg_state)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers a request once it has been open for more than mem_lat cycles.
  int   mem_cnt  = 0;
  int   mem_lat  = 1;
  logic last_resp = 1'b0;

  task automatic mem_update();
    if (!reset_n || !imem_read) begin
      mem_cnt   = 0;
      imem_resp = 1'b0;
    end else begin
      if (last_resp || mem_cnt == 0) mem_cnt = 1;
      else                           mem_cnt++;
      imem_resp = (mem_cnt > mem_lat);
    end
    last_resp  = imem_resp;
    imem_rdata = memf(imem_address);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_update();
    branch_enable = 1'b0;
  endtask

  // Stream model: decode must see consecutive PCs, restarting at target+2 after a redirect.
  logic [15:0] exp_pc;
  logic        prev_br, prev_hold, prev_pend;
  logic [15:0] prev_pc, prev_ir, prev_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc    = RESET_PC + 16'd2;
      prev_br   = 1'b0;
      prev_hold = 1'b0;
      prev_pend = 1'b0;
    end else begin
      if (prev_br) chk("flush_clears_valid", 16'(if_valid), 16'h0);
      if (prev_hold) begin
        chk("stall_hold_valid", 16'(if_valid), 16'h1);
        chk("stall_hold_pc", if_pc, prev_pc);
        chk("stall_hold_ir", if_ir, prev_ir);
      end
      if (prev_pend) begin
        chk("req_not_abandoned", 16'(imem_read), 16'h1);
        chk("req_addr_stable", imem_address, prev_addr);
      end
      if (if_valid) begin
        chk("ir_matches_pc", if_ir, memf(if_pc - 16'd2));
        if (!stall) begin
          chk("delivered_pc", if_pc, exp_pc);
          exp_pc = exp_pc + 16'd2;
        end
      end
      if (branch_enable) exp_pc = br_adder_out + 16'd2;
      prev_br   = branch_enable;
      prev_hold = if_valid && stall && !branch_enable;
      prev_pc   = if_pc;
      prev_ir   = if_ir;
      prev_pend = imem_read && !imem_resp;
      prev_addr = imem_address;
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic found;
    reset_n       = 1'b0;
    branch_enable = 1'b0;
    br_adder_out  = 16'h0000;
    stall         = 1'b0;
    imem_resp     = 1'b0;
    imem_rdata    = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Sequential fetch from reset
    chk("c0_read", 16'(imem_read), 16'h0);
    chk("c0_valid", 16'(if_valid), 16'h0);
    chk("c0_addr", imem_address, 16'h0000);
    chk("c0_state", 16'(dbg_state), 16'h0);
    tick();
    chk("c1_read", 16'(imem_read), 16'h1);
    chk("c1_addr", imem_address, 16'h0000);
    tick();
    chk("c2_valid_before_resp_edge", 16'(if_valid), 16'h0);
    tick();
    chk("c3_valid", 16'(if_valid), 16'h1);
    chk("c3_pc", if_pc, 16'h0002);
    chk("c3_ir", if_ir, memf(16'h0000));
    chk("c3_addr", imem_address, 16'h0002);
    chk("c3_read", 16'(imem_read), 16'h1);
    tick(); tick();
    chk("c5_pc", if_pc, 16'h0004);
    chk("c5_addr", imem_address, 16'h0004);
    tick(); tick();
    chk("c7_pc", if_pc, 16'h0006);
    chk("c7_ir", if_ir, memf(16'h0004));
    chk("c7_addr", imem_address, 16'h0006);

    // Stall across a response: skid capture and replay
    stall = 1'b1;
    tick();
    chk("c8_pc_held", if_pc, 16'h0006);
    tick();
    chk("c9_read_wait", 16'(imem_read), 16'h0);
    chk("c9_state", 16'(dbg_state), 16'h2);
    chk("c9_pc_held", if_pc, 16'h0006);
    tick();
    chk("c10_read_wait", 16'(imem_read), 16'h0);
    tick();
    stall = 1'b0;
    chk("c11_read_wait", 16'(imem_read), 16'h0);
    chk("c11_pc_held", if_pc, 16'h0006);
    tick();
    chk("c12_skid_pc", if_pc, 16'h0008);
    chk("c12_skid_ir", if_ir, memf(16'h0006));
    chk("c12_read", 16'(imem_read), 16'h1);
    chk("c12_addr", imem_address, 16'h0008);

    // Redirect while the 0x0008 request is still open (slow memory)
    mem_lat       = 3;
    branch_enable = 1'b1;
    br_adder_out  = 16'h1234;
    tick();
    chk("r2_addr_old", imem_address, 16'h0008);
    chk("r2_read", 16'(imem_read), 16'h1);
    chk("r2_state", 16'(dbg_state), 16'h3);
    tick();
    chk("r3_addr_old", imem_address, 16'h0008);
    tick();
    chk("r4_addr_old", imem_address, 16'h0008);
    tick();
    chk("r5_addr_target", imem_address, 16'h1234);
    chk("r5_valid", 16'(if_valid), 16'h0);
    tick(); tick(); tick();
    chk("r8_valid", 16'(if_valid), 16'h0);
    tick();
    chk("r9_valid", 16'(if_valid), 16'h1);
    chk("r9_pc", if_pc, 16'h1236);
    chk("r9_ir", if_ir, memf(16'h1234));
    mem_lat = 1;

    // Redirect on the same cycle as a response
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (imem_resp) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL t4_resp_timeout: got no response expected one within 10 cycles");
    end else begin
      chk("s0_addr", imem_address, 16'h1236);
      branch_enable = 1'b1;
      br_adder_out  = 16'h1234;
    end
    tick();
    chk("s1_addr_target", imem_address, 16'h1234);
    chk("s1_valid", 16'(if_valid), 16'h0);
    tick(); tick();
    chk("s3_pc", if_pc, 16'h1236);
    chk("s3_valid", 16'(if_valid), 16'h1);

    // Redirect while parked in WAIT, then wrap-around at 0xFFFE
    stall = 1'b1;
    tick(); tick();
    chk("s5_read_wait", 16'(imem_read), 16'h0);
    chk("s5_pc_held", if_pc, 16'h1236);
    branch_enable = 1'b1;
    br_adder_out  = 16'hFFFE;
    tick();
    chk("s6_valid", 16'(if_valid), 16'h0);
    chk("s6_addr", imem_address, 16'hFFFE);
    chk("s6_read", 16'(imem_read), 16'h1);
    stall = 1'b0;
    tick(); tick();
    chk("s8_valid", 16'(if_valid), 16'h1);
    chk("s8_pc_wrap", if_pc, 16'h0000);
    chk("s8_ir", if_ir, memf(16'hFFFE));
    chk("s8_addr_wrap", imem_address, 16'h0000);

    // Asynchronous reset mid-request, mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("rst_read", 16'(imem_read), 16'h0);
    chk("rst_valid", 16'(if_valid), 16'h0);
    chk("rst_ir", if_ir, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_addr", imem_address, RESET_PC);
    tick(); tick();
    reset_n = 1'b1;
    chk("rr0_read", 16'(imem_read), 16'h0);
    tick();
    chk("rr1_read", 16'(imem_read), 16'h1);
    chk("rr1_addr", imem_address, RESET_PC);
    tick(); tick();
    chk("rr3_pc", if_pc, 16'h0002);
    chk("rr3_ir", if_ir, memf(16'h0000));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
